// File: rtl/execute_operand_stage_if.sv
// Signal bundle between decode, the ID/EX register and the execute stage.
// The slave side is the execute_operand_stage itself.
interface execute_operand_stage_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
);
  logic                      stall_input;
  logic                      flush_input;
  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_rs_data;
  logic [DATA_WIDTH-1:0]     id_rt_data;
  logic [DATA_WIDTH-1:0]     id_immediate;
  logic [REG_ADDR_WIDTH-1:0] id_rs_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rt_addr;
  logic [REG_ADDR_WIDTH-1:0] id_rd_addr;
  logic [3:0]                id_alu_control;
  logic                      id_alu_src;
  logic                      id_reg_write;
  logic                      id_mem_read;
  logic                      id_mem_write;
  logic                      id_mem_to_reg;
  logic                      ex_mem_reg_write;
  logic [REG_ADDR_WIDTH-1:0] ex_mem_rd_addr;
  logic [DATA_WIDTH-1:0]     ex_mem_result;
  logic                      mem_wb_reg_write;
  logic [REG_ADDR_WIDTH-1:0] mem_wb_rd_addr;
  logic [DATA_WIDTH-1:0]     mem_wb_result;
  logic [DATA_WIDTH-1:0]     operand_a;
  logic [DATA_WIDTH-1:0]     operand_b;
  logic [3:0]                control_output;
  logic [DATA_WIDTH-1:0]     store_data;
  logic                      ex_valid;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr;
  logic                      ex_reg_write;
  logic                      ex_mem_read;
  logic                      ex_mem_write;
  logic                      ex_mem_to_reg;
  logic                      hazard_output;

  modport master (
    output stall_input, flush_input, id_valid, id_rs_data, id_rt_data, id_immediate,
           id_rs_addr, id_rt_addr, id_rd_addr, id_alu_control, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           ex_mem_reg_write, ex_mem_rd_addr, ex_mem_result,
           mem_wb_reg_write, mem_wb_rd_addr, mem_wb_result,
    input  operand_a, operand_b, control_output, store_data, ex_valid, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard_output
  );

  modport slave (
    input  stall_input, flush_input, id_valid, id_rs_data, id_rt_data, id_immediate,
           id_rs_addr, id_rt_addr, id_rd_addr, id_alu_control, id_alu_src,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           ex_mem_reg_write, ex_mem_rd_addr, ex_mem_result,
           mem_wb_reg_write, mem_wb_rd_addr, mem_wb_result,
    output operand_a, operand_b, control_output, store_data, ex_valid, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard_output
  );
endinterface

// File: rtl/execute_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection (one-cycle bubble).
module execute_operand_stage #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input logic                    clock,
  input logic                    reset_n,
  execute_operand_stage_if.slave bus
);

  localparam int unsigned CTRL_WIDTH = 4;

  typedef struct packed {
    logic                      valid;
    logic [DATA_WIDTH-1:0]     rs_data;
    logic [DATA_WIDTH-1:0]     rt_data;
    logic [DATA_WIDTH-1:0]     immediate;
    logic [REG_ADDR_WIDTH-1:0] rs_addr;
    logic [REG_ADDR_WIDTH-1:0] rt_addr;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [CTRL_WIDTH-1:0]     alu_control;
    logic                      alu_src;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
  } id_ex_t;

  id_ex_t                ex_q;
  id_ex_t                ex_d;
  logic                  hazard_c;
  logic [DATA_WIDTH-1:0] fwd_rs_c;
  logic [DATA_WIDTH-1:0] fwd_rt_c;

  // Load in EX whose destination is read by the instruction in decode.
  assign hazard_c = ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) && bus.id_valid &&
                    ((bus.id_rs_addr == ex_q.rd_addr) || (bus.id_rt_addr == ex_q.rd_addr));

  // Next-state selection: flush > stall > hazard bubble > capture.
  always_comb begin
    ex_d = ex_q;
    if (bus.flush_input) begin
      ex_d = '0;
    end else if (bus.stall_input) begin
      ex_d = ex_q;
    end else if (hazard_c) begin
      ex_d = '0;
    end else begin
      ex_d.valid       = bus.id_valid;
      ex_d.rs_data     = bus.id_rs_data;
      ex_d.rt_data     = bus.id_rt_data;
      ex_d.immediate   = bus.id_immediate;
      ex_d.rs_addr     = bus.id_rs_addr;
      ex_d.rt_addr     = bus.id_rt_addr;
      ex_d.rd_addr     = bus.id_rd_addr;
      ex_d.alu_control = bus.id_alu_control;
      ex_d.alu_src     = bus.id_alu_src;
      ex_d.reg_write   = bus.id_reg_write;
      ex_d.mem_read    = bus.id_mem_read;
      ex_d.mem_write   = bus.id_mem_write;
      ex_d.mem_to_reg  = bus.id_mem_to_reg;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // rs forwarding: youngest producer wins; r0 is never forwarded.
  always_comb begin
    fwd_rs_c = ex_q.rs_data;
    if (ex_q.rs_addr != '0) begin
      if (bus.ex_mem_reg_write && (bus.ex_mem_rd_addr == ex_q.rs_addr)) begin
        fwd_rs_c = bus.ex_mem_result;
      end else if (bus.mem_wb_reg_write && (bus.mem_wb_rd_addr == ex_q.rs_addr)) begin
        fwd_rs_c = bus.mem_wb_result;
      end
    end
  end

  // rt forwarding, same rules as rs.
  always_comb begin
    fwd_rt_c = ex_q.rt_data;
    if (ex_q.rt_addr != '0) begin
      if (bus.ex_mem_reg_write && (bus.ex_mem_rd_addr == ex_q.rt_addr)) begin
        fwd_rt_c = bus.ex_mem_result;
      end else if (bus.mem_wb_reg_write && (bus.mem_wb_rd_addr == ex_q.rt_addr)) begin
        fwd_rt_c = bus.mem_wb_result;
      end
    end
  end

  assign bus.operand_a      = fwd_rs_c;
  assign bus.operand_b      = ex_q.alu_src ? ex_q.immediate : fwd_rt_c;
  assign bus.store_data     = fwd_rt_c;
  assign bus.control_output = ex_q.alu_control;
  assign bus.ex_valid       = ex_q.valid;
  assign bus.ex_rd_addr     = ex_q.rd_addr;
  assign bus.ex_reg_write   = ex_q.valid & ex_q.reg_write;
  assign bus.ex_mem_read    = ex_q.valid & ex_q.mem_read;
  assign bus.ex_mem_write   = ex_q.valid & ex_q.mem_write;
  assign bus.ex_mem_to_reg  = ex_q.valid & ex_q.mem_to_reg;
  assign bus.hazard_output  = hazard_c;

endmodule

// File: tb/tb_execute_operand_stage.sv
// Directed bench for execute_operand_stage: expected EX state is queued when an
// instruction is driven and compared once it reaches the registered outputs.
module tb_execute_operand_stage;

  logic clock;
  logic reset_n;
  int   evaluated = 0;
  int   failures  = 0;

  execute_operand_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  execute_operand_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        mtr;
  } exp_t;

  exp_t sb[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $error("FAIL timeout: observed no finish, expected finish before 50000");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [31:0] rsd,
                          input logic [4:0] rt, input logic [31:0] rtd, input logic [4:0] rd,
                          input logic [31:0] imm, input logic [3:0] ctrl, input logic src,
                          input logic rw, input logic mr, input logic mw, input logic mtr);
    bus.id_valid = v;       bus.id_rs_addr = rs;   bus.id_rs_data = rsd;
    bus.id_rt_addr = rt;    bus.id_rt_data = rtd;  bus.id_rd_addr = rd;
    bus.id_immediate = imm; bus.id_alu_control = ctrl; bus.id_alu_src = src;
    bus.id_reg_write = rw;  bus.id_mem_read = mr;  bus.id_mem_write = mw;
    bus.id_mem_to_reg = mtr;
  endtask

  task automatic push(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] ctrl, input logic [31:0] st, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw, input logic mtr);
    exp_t e;
    e.valid = v; e.a = a; e.b = b; e.ctrl = ctrl; e.st = st; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr;
    sb.push_back(e);
  endtask

  task automatic check_ex(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, " ex_valid"},       32'(bus.ex_valid),       32'(e.valid));
    chk({tag, " operand_a"},      bus.operand_a,           e.a);
    chk({tag, " operand_b"},      bus.operand_b,           e.b);
    chk({tag, " control_output"}, 32'(bus.control_output), 32'(e.ctrl));
    chk({tag, " store_data"},     bus.store_data,          e.st);
    chk({tag, " ex_rd_addr"},     32'(bus.ex_rd_addr),     32'(e.rd));
    chk({tag, " ex_reg_write"},   32'(bus.ex_reg_write),   32'(e.rw));
    chk({tag, " ex_mem_read"},    32'(bus.ex_mem_read),    32'(e.mr));
    chk({tag, " ex_mem_write"},   32'(bus.ex_mem_write),   32'(e.mw));
    chk({tag, " ex_mem_to_reg"},  32'(bus.ex_mem_to_reg),  32'(e.mtr));
  endtask

  task automatic set_fwd(input logic emw, input logic [4:0] emrd, input logic [31:0] emr,
                         input logic mww, input logic [4:0] mwrd, input logic [31:0] mwr);
    bus.ex_mem_reg_write = emw; bus.ex_mem_rd_addr = emrd; bus.ex_mem_result = emr;
    bus.mem_wb_reg_write = mww; bus.mem_wb_rd_addr = mwrd; bus.mem_wb_result = mwr;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.stall_input = 1'b0;
    bus.flush_input = 1'b0;
    drive_id(1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #12;

    // Reset state.
    push(1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_ex("reset");
    chk("reset hazard", 32'(bus.hazard_output), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Plain ADD, no forwarding.
    drive_id(1'b1, 5'd3, 32'd5, 5'd4, 32'd7, 5'd10, 32'd0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 32'd5, 32'd7, 4'b0010, 32'd7, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_ex("add");
    chk("add hazard", 32'(bus.hazard_output), 32'd0);

    // Double forward of r8: EX/MEM beats MEM/WB, then MEM/WB alone.
    drive_id(1'b1, 5'd8, 32'h99, 5'd0, 32'h55, 5'd12, 32'd0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_fwd(1'b1, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22);
    push(1'b1, 32'h11, 32'h55, 4'b0110, 32'h55, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_ex("dfwd");
    bus.ex_mem_reg_write = 1'b0;
    #1;
    chk("dfwd memwb operand_a", bus.operand_a, 32'h22);

    // Producers targeting r0 are ignored.
    drive_id(1'b1, 5'd0, 32'h33, 5'd0, 32'h66, 5'd13, 32'd0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_fwd(1'b1, 5'd0, 32'h44, 1'b1, 5'd0, 32'h45);
    push(1'b1, 32'h33, 32'h66, 4'b0001, 32'h66, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_ex("r0");

    // Load-use: lw r9 followed by a reader of r9.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(1'b1, 5'd1, 32'h100, 5'd9, 32'd0, 5'd9, 32'd4, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b1, 32'h100, 32'd4, 4'b0010, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_ex("lw");
    drive_id(1'b1, 5'd9, 32'h7, 5'd2, 32'h3, 5'd11, 32'd0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("loaduse hazard", 32'(bus.hazard_output), 32'd1);
    push(1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_ex("bubble");
    chk("bubble hazard", 32'(bus.hazard_output), 32'd0);
    set_fwd(1'b1, 5'd9, 32'h500, 1'b0, 5'd0, 32'd0);
    push(1'b1, 32'h500, 32'h3, 4'b0010, 32'h3, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_ex("after_bubble");

    // A load into r0 never raises a hazard.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(1'b1, 5'd1, 32'h10, 5'd0, 32'd0, 5'd0, 32'd8, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    push(1'b1, 32'h10, 32'd8, 4'b0010, 32'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_ex("lw_r0");
    drive_id(1'b1, 5'd0, 32'd0, 5'd0, 32'd0, 5'd14, 32'd0, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("lw_r0 hazard", 32'(bus.hazard_output), 32'd0);

    // Flush wins over stall.
    drive_id(1'b1, 5'd5, 32'd1, 5'd6, 32'd2, 5'd12, 32'd0, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus.flush_input = 1'b1;
    bus.stall_input = 1'b1;
    push(1'b0, 32'd0, 32'd0, 4'b0000, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_ex("flush_stall");
    bus.flush_input = 1'b0;
    bus.stall_input = 1'b0;
    push(1'b1, 32'd1, 32'd2, 4'b0110, 32'd2, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_ex("sub");

    // Stall holds for three cycles; forwarding still tracks new results.
    bus.stall_input = 1'b1;
    drive_id(1'b1, 5'd20, 32'hDEAD, 5'd21, 32'hBEEF, 5'd22, 32'h1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h77);
      push(1'b1, (i == 2) ? 32'h77 : 32'd1, 32'd2, 4'b0110, 32'd2, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      check_ex($sformatf("stall%0d", i));
    end
    bus.stall_input = 1'b0;

    // Immediate store with rt forwarded from MEM/WB.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAB);
    drive_id(1'b1, 5'd1, 32'h1000, 5'd7, 32'h5, 5'd0, 32'hFFFF_FFFC, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(1'b1, 32'h1000, 32'hFFFF_FFFC, 4'b0010, 32'hAB, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_ex("sw_imm");

    // Invalid decode slot: controls gated off even though bits are set.
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    drive_id(1'b0, 5'd2, 32'h2A, 5'd3, 32'h3B, 5'd4, 32'd0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1'b0, 32'h2A, 32'h3B, 4'b0001, 32'h3B, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_ex("invalid");

    // Asynchronous reset mid-cycle discards the instruction in EX.
    drive_id(1'b1, 5'd6, 32'h60, 5'd7, 32'h70, 5'd8, 32'd0, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    push(1'b1, 32'h60, 32'h70, 4'b1101, 32'h70, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check_ex("xor");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst ex_valid",       32'(bus.ex_valid),       32'd0);
    chk("async_rst control_output", 32'(bus.control_output), 32'd0);
    chk("async_rst operand_a",      bus.operand_a,           32'd0);
    chk("async_rst operand_b",      bus.operand_b,           32'd0);
    chk("async_rst ex_reg_write",   32'(bus.ex_reg_write),   32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
